seq_mul_hs: RTL and testbench

//  Iterative shift-add multiplier: one multiplier bit per clock, WIDTH-bit operands, 2*WIDTH-bit product.

---
 rtl/seq_mul_hs_if.sv | 20 ++
 rtl/seq_mul_hs.sv | 60 ++++++
 tb/tb_seq_mul_hs.sv | 124 ++++++++++++
 3 files changed

// File: rtl/seq_mul_hs_if.sv
// seq_mul_hs_if: operand/result handshake bundle for the sequential multiplier
interface seq_mul_hs_if #(parameter int WIDTH = 8);
    logic                 in_valid;
    logic                 in_ready;
    logic                 signed_mode;
    logic [WIDTH-1:0]     num1;
    logic [WIDTH-1:0]     num2;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   result;
    logic                 busy;
    modport master (
        output in_valid, signed_mode, num1, num2, out_ready,
        input  in_ready, out_valid, result, busy
    );
    modport slave (
        input  in_valid, signed_mode, num1, num2, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/seq_mul_hs.sv
// seq_mul_hs: shift-add multiplier, one multiplier bit per clock, valid/ready on both sides
module seq_mul_hs #(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b0
) (
    input logic           clk,
    input logic           rst_n,
    seq_mul_hs_if.slave   bus
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t             state, state_next;
    logic [WIDTH-1:0]   mcand, mplier, mag1, mag2;
    logic               neg, last, accept;
    logic [2*WIDTH-1:0] acc, acc_next, result_q;
    logic [CW-1:0]      count;
    assign accept   = state == IDLE && bus.in_valid;
    assign mag1     = (bus.signed_mode && bus.num1[WIDTH-1]) ? -bus.num1 : bus.num1;
    assign mag2     = (bus.signed_mode && bus.num2[WIDTH-1]) ? -bus.num2 : bus.num2;
    assign acc_next = acc + (mplier[0] ? ({{WIDTH{1'b0}}, mcand} << count) : '0);
    // early exit fires once no set bits remain above the one consumed this step
    assign last     = count == CW'(WIDTH - 1) || (EARLY_EXIT && mplier[WIDTH-1:1] == '0);
    always_ff @(posedge clk)
        state <= !rst_n ? IDLE : state_next;
    always_comb begin
        state_next = state;
        if (accept)
            state_next = CALC;
        else if (state == CALC && last)
            state_next = DONE;
        else if (state == DONE && bus.out_ready)
            state_next = IDLE;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand    <= '0;
            mplier   <= '0;
            neg      <= 1'b0;
            acc      <= '0;
            count    <= '0;
            result_q <= '0;
        end else if (accept) begin
            mcand  <= mag1;
            mplier <= mag2;
            neg    <= bus.signed_mode & (bus.num1[WIDTH-1] ^ bus.num2[WIDTH-1]);
            acc    <= '0;
            count  <= '0;
        end else if (state == CALC) begin
            acc    <= acc_next;
            mplier <= mplier >> 1;
            count  <= count + CW'(1);
            if (last)
                result_q <= neg ? -acc_next : acc_next;
        end
    end
    assign bus.in_ready  = state == IDLE;
    assign bus.out_valid = state == DONE;
    assign bus.busy      = state != IDLE;
    assign bus.result    = result_q;
endmodule

// File: tb/tb_seq_mul_hs.sv
// tb_seq_mul_hs: directed and random checks of seq_mul_hs with EARLY_EXIT off (u0) and on (u1)
module tb_seq_mul_hs;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        iv = 1'b0, sm = 1'b0, ordy = 1'b0, sel = 1'b0;
    logic [7:0]  n1 = '0, n2 = '0;
    logic        ov, ir, bsy;
    logic [15:0] res;
    int          vecs = 0, miscompares = 0;
    always #5 clk = ~clk;
    seq_mul_hs_if #(.WIDTH(8)) b0 ();
    seq_mul_hs_if #(.WIDTH(8)) b1 ();
    seq_mul_hs #(.WIDTH(8), .EARLY_EXIT(1'b0)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    seq_mul_hs #(.WIDTH(8), .EARLY_EXIT(1'b1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    assign b0.in_valid    = iv & ~sel;
    assign b1.in_valid    = iv & sel;
    assign b0.signed_mode = sm;
    assign b1.signed_mode = sm;
    assign b0.num1        = n1;
    assign b1.num1        = n1;
    assign b0.num2        = n2;
    assign b1.num2        = n2;
    assign b0.out_ready   = ordy;
    assign b1.out_ready   = ordy;
    assign ov  = sel ? b1.out_valid : b0.out_valid;
    assign ir  = sel ? b1.in_ready  : b0.in_ready;
    assign bsy = sel ? b1.busy      : b0.busy;
    assign res = sel ? b1.result    : b0.result;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    function automatic int ref_lat(input bit e, input bit s, input logic [7:0] b);
        logic [7:0] m;
        int h;
        m = (s && b[7]) ? 8'(-b) : b;
        h = 0;
        if (!e) return 9;
        for (int i = 0; i < 8; i++) if (m[i]) h = i + 1;
        return (h == 0) ? 2 : 1 + h;
    endfunction
    function automatic logic [15:0] ref_prod(input bit s, input logic [7:0] a, input logic [7:0] b);
        logic        [15:0] ua, ub;
        logic signed [15:0] sa, sb;
        ua = {8'b0, a};
        ub = {8'b0, b};
        sa = $signed(a);
        sb = $signed(b);
        return s ? 16'(sa * sb) : 16'(ua * ub);
    endfunction
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic mul(input bit e, input bit s, input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] exp, input int stall);
        int k;
        sel = e; sm = s; n1 = a; n2 = b; iv = 1'b1; ordy = 1'b0;
        chk("in_ready_idle", ir, 1);
        tick();
        iv = 1'b0;
        k = 1;
        while (!ov && k < 40) begin
            chk("busy_calc", {bsy, ir}, 2'b10);
            iv = 1'($urandom); sm = 1'($urandom); n1 = 8'($urandom); n2 = 8'($urandom);
            tick();
            k++;
        end
        chk("latency", k, ref_lat(e, s, b));
        chk("result", res, exp);
        iv = 1'b1;
        for (int i = 0; i < stall; i++) begin
            tick();
            chk("stall_hold", {ov, ir, res}, {2'b10, exp});
        end
        iv = 1'b0; ordy = 1'b1;
        tick();
        ordy = 1'b0;
        chk("consumed", {ir, ov, bsy}, 3'b100);
    endtask
    initial begin
        tick();
        tick();
        chk("reset_u0", {b0.in_ready, b0.out_valid, b0.busy, b0.result}, {3'b100, 16'h0});
        chk("reset_u1", {b1.in_ready, b1.out_valid, b1.busy, b1.result}, {3'b100, 16'h0});
        rst_n = 1'b1;
        tick();
        mul(0, 0, 8'hFF, 8'hFF, 16'hFE01, 5);
        mul(0, 1, 8'h80, 8'h80, 16'h4000, 0);
        mul(0, 1, 8'h80, 8'h7F, 16'hC080, 1);
        mul(0, 1, 8'hFD, 8'h05, 16'hFFF1, 0);
        mul(0, 1, 8'h00, 8'hFF, 16'h0000, 0);
        mul(0, 0, 8'h0C, 8'h0B, 16'h0084, 0);
        mul(1, 0, 8'h37, 8'h01, 16'h0037, 0);
        mul(1, 0, 8'h03, 8'h80, 16'h0180, 2);
        mul(1, 1, 8'h80, 8'h80, 16'h4000, 0);
        mul(1, 0, 8'h55, 8'h00, 16'h0000, 0);
        mul(1, 1, 8'hFD, 8'h05, 16'hFFF1, 0);
        mul(1, 1, 8'h07, 8'hFF, 16'hFFF9, 0);
        // abort mid-calculation: prior result must be wiped, then a clean transaction follows
        sel = 1'b0; sm = 1'b0; n1 = 8'h12; n2 = 8'h34; iv = 1'b1;
        tick();
        iv = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("reset_mid_calc", {b0.out_valid, b0.in_ready, b0.busy, b0.result}, {3'b010, 16'h0});
        mul(0, 0, 8'h12, 8'h34, 16'h03A8, 0);
        for (int t = 0; t < 300; t++) begin
            logic       e, s;
            logic [7:0] a, b;
            e = 1'($urandom); s = 1'($urandom); a = 8'($urandom); b = 8'($urandom);
            if (t % 7 == 0) b = 8'($urandom_range(0, 3));
            mul(e, s, a, b, ref_prod(s, a, b), int'($urandom_range(0, 2)));
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end
endmodule
